// File: rtl/truth_table_reader.sv
// truth_table_reader: rebuilds the truth table of an unknown 2-input Boolean
// function from observed (x, y, s) samples, flags inconsistent samples and
// classifies the recovered function (constant, x/y dependency, linearity).
//
// Handshake: in_valid is a pure strobe with no ready. A sample is consumed on
// every rising clk edge where in_valid is high, unless reset or clear is also
// high on that edge, in which case the sample is discarded. Back-to-back
// samples are legal.

module truth_table_reader #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    input  logic             s,
    output logic [3:0]       table_out,
    output logic [3:0]       seen,
    output logic             done,
    output logic             conflict,
    output logic             is_const,
    output logic             dep_x,
    output logic             dep_y,
    output logic             is_linear,
    output logic [CNT_W-1:0] sample_count
);

    // IDLE: nothing recorded; COLLECT: some rows known; DONE: table complete;
    // ERROR: a sample contradicted a stored row, held until reset/clear.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] row;
    logic [3:0] row_bit;
    logic [3:0] seen_next;
    logic       row_match;

    assign row       = {x, y};
    assign row_bit   = 4'b0001 << row;
    assign seen_next = seen | row_bit;
    assign row_match = (table_out[row] == s);

    // Sample acceptance, row recording, conflict detection and counting.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state        <= IDLE;
            table_out    <= 4'b0000;
            seen         <= 4'b0000;
            done         <= 1'b0;
            conflict     <= 1'b0;
            sample_count <= '0;
        end else if (in_valid) begin
            // Counting happens in every state, including ERROR.
            if (sample_count != {CNT_W{1'b1}}) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    table_out[row] <= s;
                    seen           <= seen_next;
                    state          <= COLLECT;
                end
                COLLECT: begin
                    if (!seen[row]) begin
                        table_out[row] <= s;
                        seen           <= seen_next;
                        if (seen_next == 4'b1111) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (!row_match) begin
                        state    <= ERROR;
                        conflict <= 1'b1;
                    end
                end
                DONE: begin
                    if (!row_match) begin
                        state    <= ERROR;
                        conflict <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ERROR: begin
                    // Table and seen stay frozen; only the counter moves.
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    logic raw_dep_x;
    logic raw_dep_y;
    logic raw_linear;

    // Classify the stored table; flags are only meaningful once done is high.
    always_comb begin
        raw_dep_x  = (table_out[0] != table_out[2]) | (table_out[1] != table_out[3]);
        raw_dep_y  = (table_out[0] != table_out[1]) | (table_out[2] != table_out[3]);
        raw_linear = 1'b0;
        case (table_out)
            4'b0000, 4'b1111, 4'b0110, 4'b1001,
            4'b1100, 4'b0011, 4'b1010, 4'b0101: raw_linear = 1'b1;
            default:                            raw_linear = 1'b0;
        endcase
        dep_x     = done & raw_dep_x;
        dep_y     = done & raw_dep_y;
        is_const  = done & ~raw_dep_x & ~raw_dep_y;
        is_linear = done & raw_linear;
    end

endmodule

// File: tb/tb_truth_table_reader.sv
// Bench for truth_table_reader: directed scenarios plus randomized episodes,
// all checked against a row-array reference model of the observer.

module tb_truth_table_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic x = 1'b0;
  logic y = 1'b0;
  logic s = 1'b0;

  logic [3:0] table_out, seen;
  logic       done, conflict, is_const, dep_x, dep_y, is_linear;
  logic [7:0] sample_count;

  logic [3:0] s2_table_out, s2_seen;
  logic       s2_done, s2_conflict, s2_is_const, s2_dep_x, s2_dep_y, s2_is_linear;
  logic [1:0] s2_sample_count;

  truth_table_reader #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .x(x), .y(y), .s(s),
    .table_out(table_out), .seen(seen), .done(done), .conflict(conflict),
    .is_const(is_const), .dep_x(dep_x), .dep_y(dep_y), .is_linear(is_linear),
    .sample_count(sample_count)
  );

  truth_table_reader #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .x(x), .y(y), .s(s),
    .table_out(s2_table_out), .seen(s2_seen), .done(s2_done), .conflict(s2_conflict),
    .is_const(s2_is_const), .dep_x(s2_dep_x), .dep_y(s2_dep_y), .is_linear(s2_is_linear),
    .sample_count(s2_sample_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic m_tab [4];
  logic m_seen [4];
  logic m_conflict;
  int   m_count;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_tab[i]  = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_conflict = 1'b0;
    m_count    = 0;
  endfunction

  function automatic void model_sample(input logic vx, input logic vy, input logic vs);
    int r;
    r = vx * 2 + vy;
    m_count++;
    if (!m_conflict) begin
      if (m_seen[r]) begin
        if (m_tab[r] != vs) m_conflict = 1'b1;
      end else begin
        m_tab[r]  = vs;
        m_seen[r] = 1'b1;
      end
    end
  endfunction

  function automatic logic f_at(input logic [3:0] t, input int fx, input int fy);
    logic [3:0] tt;
    tt = t;
    return tt[fx * 2 + fy];
  endfunction

  // Expected {table, seen, done, conflict, is_const, dep_x, dep_y, is_linear, count}
  function automatic logic [21:0] exp_vec(input int cmax);
    logic [3:0] t, sn;
    logic d, dx, dy, cst, lin, fits;
    int cnt;
    for (int i = 0; i < 4; i++) begin
      t[i]  = m_tab[i];
      sn[i] = m_seen[i];
    end
    d  = (sn == 4'b1111) && !m_conflict;
    dx = 1'b0;
    dy = 1'b0;
    for (int v = 0; v < 2; v++) begin
      if (f_at(t, 0, v) != f_at(t, 1, v)) dx = 1'b1;
      if (f_at(t, v, 0) != f_at(t, v, 1)) dy = 1'b1;
    end
    cst = (t == 4'b0000) || (t == 4'b1111);
    // Linear (affine over GF(2)): f = c ^ a*x ^ b*y for some a, b, c.
    lin = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) begin
          fits = 1'b1;
          for (int fx = 0; fx < 2; fx++)
            for (int fy = 0; fy < 2; fy++)
              if (f_at(t, fx, fy) != logic'((c + a * fx + b * fy) % 2)) fits = 1'b0;
          if (fits) lin = 1'b1;
        end
    cnt = (m_count > cmax) ? cmax : m_count;
    return {t, sn, d, m_conflict, d & cst, d & dx, d & dy, d & lin, 8'(cnt)};
  endfunction

  function automatic logic [21:0] obs_main();
    return {table_out, seen, done, conflict, is_const, dep_x, dep_y, is_linear, sample_count};
  endfunction

  function automatic logic [21:0] obs_sat();
    return {s2_table_out, s2_seen, s2_done, s2_conflict, s2_is_const, s2_dep_x, s2_dep_y,
            s2_is_linear, 6'b0, s2_sample_count};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vx, input logic vy, input logic vs);
    @(negedge clk);
    x = vx; y = vy; s = vs; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_sample(vx, vy, vs);
  endtask

  task automatic restart(input bit use_clear, input logic with_valid);
    @(negedge clk);
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    in_valid = with_valid;
    x = 1'($urandom_range(0, 1));
    y = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    n_checks++;
    if (obs_main() !== exp_vec(255))
      $display("FAIL reset_state: got %h expected %h", obs_main(), exp_vec(255));
    else n_pass++;
    n_checks++;
    if ({table_out, seen, done, conflict, sample_count} !== 18'd0)
      $display("FAIL reset_zero: got %h expected 0", {table_out, seen, done, conflict, sample_count});
    else n_pass++;
  endtask

  task automatic test_and_sweep();
    restart(1'b0, 1'b0);
    drive(0, 0, 0); drive(0, 1, 0); drive(1, 0, 0);
    n_checks++;
    if (done !== 1'b0) $display("FAIL and_not_done_yet: got %b expected 0", done);
    else n_pass++;
    drive(1, 1, 1);
    n_checks++;
    if (obs_main() !== exp_vec(255))
      $display("FAIL and_model: got %h expected %h", obs_main(), exp_vec(255));
    else n_pass++;
    n_checks++;
    if ({table_out, done, dep_x, dep_y, is_const, is_linear, sample_count} !== {4'b1000, 5'b11100, 8'd4})
      $display("FAIL and_values: got %h expected %h",
               {table_out, done, dep_x, dep_y, is_const, is_linear, sample_count}, {4'b1000, 5'b11100, 8'd4});
    else n_pass++;
  endtask

  task automatic test_xnor_and_const();
    restart(1'b1, 1'b0);
    drive(1, 1, 1); drive(1, 0, 0); drive(0, 1, 0); drive(0, 0, 1);
    n_checks++;
    if ({table_out, done, is_linear, dep_x, dep_y, is_const} !== {4'b1001, 5'b11110})
      $display("FAIL xnor_values: got %h expected %h",
               {table_out, done, is_linear, dep_x, dep_y, is_const}, {4'b1001, 5'b11110});
    else n_pass++;
    restart(1'b0, 1'b0);
    for (int r = 0; r < 4; r++) drive(1'(r >> 1), 1'(r), 1'b1);
    n_checks++;
    if ({table_out, done, is_const, is_linear, dep_x, dep_y} !== {4'b1111, 5'b11100})
      $display("FAIL const1_values: got %h expected %h",
               {table_out, done, is_const, is_linear, dep_x, dep_y}, {4'b1111, 5'b11100});
    else n_pass++;
  endtask

  task automatic test_duplicates();
    int rows [6] = '{0, 0, 1, 1, 2, 3};
    restart(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'(rows[i] >> 1), 1'(rows[i]), 1'(rows[i]));
      n_checks++;
      if (done !== (i == 5))
        $display("FAIL dup_done_step%0d: got %b expected %b", i, done, (i == 5));
      else n_pass++;
    end
    n_checks++;
    if ({table_out, dep_x, dep_y, sample_count} !== {4'b1010, 2'b01, 8'd6})
      $display("FAIL dup_values: got %h expected %h",
               {table_out, dep_x, dep_y, sample_count}, {4'b1010, 2'b01, 8'd6});
    else n_pass++;
  endtask

  task automatic test_conflict_collect();
    restart(1'b0, 1'b0);
    drive(0, 1, 0); drive(0, 1, 1);
    n_checks++;
    if ({conflict, done, table_out[1], seen} !== {3'b100, 4'b0010})
      $display("FAIL conflict_values: got %h expected %h", {conflict, done, table_out[1], seen}, {3'b100, 4'b0010});
    else n_pass++;
    for (int i = 0; i < 3; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_checks++;
    if (obs_main() !== exp_vec(255))
      $display("FAIL conflict_frozen: got %h expected %h", obs_main(), exp_vec(255));
    else n_pass++;
    restart(1'b1, 1'b0);
    n_checks++;
    if (obs_main() !== 22'd0) $display("FAIL conflict_clear: got %h expected 0", obs_main());
    else n_pass++;
  endtask

  task automatic test_post_done_mismatch();
    restart(1'b0, 1'b0);
    drive(0, 0, 0); drive(0, 1, 1); drive(1, 0, 1); drive(1, 1, 1);
    n_checks++;
    if ({table_out, done} !== 5'b11101) $display("FAIL or_done: got %b expected 11101", {table_out, done});
    else n_pass++;
    drive(0, 0, 1);
    n_checks++;
    if ({done, conflict, is_const, dep_x, dep_y, is_linear, table_out} !== {6'b010000, 4'b1110})
      $display("FAIL post_done_mismatch: got %h expected %h",
               {done, conflict, is_const, dep_x, dep_y, is_linear, table_out}, {6'b010000, 4'b1110});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    restart(1'b0, 1'b0);
    drive(0, 0, 1); drive(1, 1, 0);
    restart(1'b0, 1'b0);
    n_checks++;
    if (obs_main() !== 22'd0) $display("FAIL reset_mid: got %h expected 0", obs_main());
    else n_pass++;
    drive(1, 0, 1);
    restart(1'b0, 1'b1);
    n_checks++;
    if (obs_main() !== 22'd0) $display("FAIL reset_with_valid: got %h expected 0", obs_main());
    else n_pass++;
    restart(1'b1, 1'b1);
    n_checks++;
    if (obs_main() !== 22'd0) $display("FAIL clear_with_valid: got %h expected 0", obs_main());
    else n_pass++;
    drive(1, 0, 1);
    n_checks++;
    if ({seen, table_out, done, sample_count} !== {4'b0100, 4'b0100, 1'b0, 8'd1})
      $display("FAIL restart_from_idle: got %h expected %h",
               {seen, table_out, done, sample_count}, {4'b0100, 4'b0100, 1'b0, 8'd1});
    else n_pass++;
  endtask

  task automatic test_saturation();
    restart(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0);
    n_checks++;
    if ({s2_sample_count, sample_count} !== {2'd3, 8'd5})
      $display("FAIL saturation: got %h expected %h", {s2_sample_count, sample_count}, {2'd3, 8'd5});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] f;
    int n, r;
    logic flip;
    for (int ep = 0; ep < 16; ep++) begin
      f = 4'($urandom_range(0, 15));
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 3);
        flip = ($urandom_range(0, 19) == 0);
        drive(1'(r >> 1), 1'(r), f[r] ^ flip);
        n_checks++;
        if (obs_main() !== exp_vec(255))
          $display("FAIL random_main ep%0d k%0d: got %h expected %h", ep, k, obs_main(), exp_vec(255));
        else n_pass++;
        n_checks++;
        if (obs_sat() !== exp_vec(3))
          $display("FAIL random_sat ep%0d k%0d: got %h expected %h", ep, k, obs_sat(), exp_vec(3));
        else n_pass++;
      end
      restart(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs_main() !== exp_vec(255))
        $display("FAIL random_restart ep%0d: got %h expected %h", ep, obs_main(), exp_vec(255));
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_and_sweep();
    test_xnor_and_const();
    test_duplicates();
    test_conflict_collect();
    test_post_done_mismatch();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_reader.md
# truth_table_reader

Sequential observer that reconstructs the truth table of an unknown 2-input Boolean function from a stream of (x, y, s) samples and classifies it. It sits on the output side of the fxyz-style 2-input function modules: where those modules map inputs to an output, this block takes the observed outputs and recovers the function. It accumulates rows and detects inconsistent samples. Once all four rows are known, it reports the 4-bit function code plus dependency and linearity flags.

## Interface
- CNT_W, 8, width of saturating accepted-sample counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- clear  in  1  synchronous restart to IDLE; same effect as reset
- in_valid  in  1  sample strobe; x, y, s sampled when high
- x  in  1  function input x
- y  in  1  function input y
- s  in  1  observed function output
- table_out  out  4  table_out[{x,y}] = s; row 0 = x0y0, 1 = x0y1, 2 = x1y0, 3 = x1y1
- seen  out  4  seen[r] = 1 once row r has been recorded
- done  out  1  all four rows known, no conflict
- conflict  out  1  sticky; a sample disagreed with a stored row
- is_const  out  1  valid only with done; table_out is 0000 or 1111
- dep_x  out  1  valid only with done; output depends on x
- dep_y  out  1  valid only with done; output depends on y
- is_linear  out  1  valid only with done; table_out is in {0000, 1111, 0110, 1001, 1100, 0011, 1010, 0101}
- sample_count  out  CNT_W  accepted samples, saturating at 2^CNT_W-1

## Operation
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). Reset has priority over clear, and clear has priority over in_valid.
- Reset/clear values: state = IDLE, table_out = 0, seen = 0, done = 0, conflict = 0, sample_count = 0. The classification flags are therefore 0.
- States: IDLE, COLLECT, DONE, ERROR.
- Row index: r = {x, y}.
- IDLE, on in_valid: table_out[r] <= s, seen[r] <= 1, go to COLLECT.
- COLLECT, on in_valid:
  - If seen[r] = 0: record the sample as in IDLE.
  - If seen[r] = 1 and table_out[r] == s: no change.
  - If seen[r] = 1 and table_out[r] != s: go to ERROR, conflict <= 1, table_out unchanged.
  - If the update makes seen = 1111 with no conflict: go to DONE, done <= 1.
- DONE, on in_valid: check the sample against table_out[r]. On mismatch go to ERROR, conflict <= 1, done <= 0. On match, stay in DONE.
- ERROR: absorbing until reset or clear. table_out and seen stay frozen; further samples are ignored apart from counting.
- sample_count increments by 1 on every in_valid that is not overridden by reset or clear, in every state. It holds at all-ones.
- Classification is combinational from table_out, ANDed with done:
  - dep_x = (t[0] != t[2]) | (t[1] != t[3])
  - dep_y = (t[0] != t[1]) | (t[2] != t[3])
  - is_const = !dep_x & !dep_y
  - is_linear = membership in the set listed under is_linear

## Timing
- All outputs except the classification flags are registered.
- A sample presented with in_valid on edge N is visible on table_out, seen and sample_count after edge N.
- done rises after the edge that accepts the fourth distinct row. A minimum of 4 consecutive in_valid cycles reaches done.
- conflict and the done drop occur after the edge that accepts the offending sample.
- No backpressure: in_valid is accepted every cycle, and back-to-back samples are legal.
- Reset or clear asserted in the same cycle as in_valid: the sample is discarded and all outputs are 0 after that edge.
- Reset mid-COLLECT discards partial rows. The next sample restarts from IDLE.

## Test plan
- AND sweep, samples (0,0,0), (0,1,0), (1,0,0), (1,1,1) on consecutive cycles -> done = 1 after the 4th edge; table_out = 1000, dep_x = dep_y = 1, is_const = 0, is_linear = 0, sample_count = 4.
- XNOR sweep in reverse row order 3, 2, 1, 0 with s = 1, 0, 0, 1 -> table_out = 1001, done = 1, is_linear = 1, dep_x = dep_y = 1. Constant-1 sweep -> table_out = 1111, is_const = 1, is_linear = 1.
- Duplicates before completion: rows 0, 0, 1, 1, 2, 3 with consistent s for fxyzC (s = y) -> done = 1 only after the 6th sample; table_out = 1010, dep_x = 0, dep_y = 1, sample_count = 6.
- Conflict in COLLECT: (0,1,0) then (0,1,1) -> conflict = 1, done = 0, table_out[1] = 0, seen = 0010. Further samples change only sample_count. Pulsing clear -> all outputs 0.
- Post-done mismatch: complete an OR table (1110), then send (0,0,1) -> done = 0, conflict = 1, flags all 0.
- Reset mid-collection after 2 rows, then reset coincident with in_valid -> all outputs 0. With CNT_W = 2, sending 5 samples -> sample_count saturates at 3.
